echo_canceller: RTL

ECHO_CANCELLER -- requirements
Module: echo_canceller

---
 rtl/echo_canceller_pkg.sv | 23 ++
 rtl/echo_canceller_delay_line.sv | 51 +++++
 rtl/echo_canceller.sv | 112 +++++++++++
 3 files changed

// File: rtl/echo_canceller_pkg.sv
// Shared defaults, gain code encoding and FSM state encoding for the echo canceller.
package echo_canceller_pkg;

    localparam int SIZE_DEFAULT      = 8;
    localparam int ADDR_SIZE_DEFAULT = 11;
    localparam int DIV_DEFAULT       = 4;

    // Gain is beta/4, applied as multiply by the code then shift right by GAIN_SHIFT.
    localparam int GAIN_SHIFT = 2;

    typedef enum logic [1:0] {
        GAIN_ZERO     = 2'd0,
        GAIN_QUARTER  = 2'd1,
        GAIN_HALF     = 2'd2,
        GAIN_3QUARTER = 2'd3
    } gain_e;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/echo_canceller_delay_line.sv
// DEPTH x SIZE single-port RAM with a free-running write pointer; the read
// issued at a tick returns the sample written DEPTH ticks earlier.
module echo_delay_line
    import echo_canceller_pkg::*;
#(
    parameter int SIZE      = SIZE_DEFAULT,
    parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_en,
    input  logic            wr_en,
    input  logic [SIZE-1:0] wr_data,
    output logic [SIZE-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [SIZE-1:0]      mem [DEPTH];
    logic [SIZE-1:0]      rd_data_q;
    logic [ADDR_SIZE-1:0] wr_ptr_q;
    logic [ADDR_SIZE-1:0] wr_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Contents survive reset; a write landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr_q] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[wr_ptr_q];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/echo_canceller.sv
// Removes a single delayed echo: sound = echo - (beta/4) * echo[n-DEPTH],
// floored at zero, one output per sample tick.
module echo_canceller
    import echo_canceller_pkg::*;
#(
    parameter int SIZE      = SIZE_DEFAULT,
    parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT,
    parameter int DIV       = DIV_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [SIZE-1:0] echo,
    input  logic [1:0]      beta,
    output logic [SIZE-1:0] sound,
    output logic            sound_valid
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0]        count_q, count_d;
    logic                 valid_q, valid_d;
    logic [SIZE-1:0]      echo_q, echo_d;
    gain_e                beta_q, beta_d;
    logic [ADDR_SIZE-1:0] fill_cnt_q, fill_cnt_d;
    state_e               state_q, state_d;
    logic [SIZE-1:0]      sound_q, sound_d;
    logic                 sound_valid_q, sound_valid_d;

    logic                 tick;
    logic [SIZE-1:0]      rd_data;
    logic [SIZE-1:0]      delayed;
    logic [SIZE+1:0]      product;
    logic [SIZE+1:0]      scaled;
    logic [SIZE+1:0]      echo_wide;

    assign tick = en && (count_q == CW'(DIV - 1));

    echo_delay_line #(
        .SIZE      (SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_delay_line (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (tick),
        .wr_en   (valid_q),
        .wr_data (echo_q),
        .rd_data (rd_data)
    );

    // Stale RAM contents are masked until DEPTH samples have been written.
    always_comb begin
        delayed   = (state_q == RUN) ? rd_data : '0;
        product   = {2'b00, delayed} * {{SIZE{1'b0}}, beta_q};
        scaled    = product >> GAIN_SHIFT;
        echo_wide = {2'b00, echo_q};
    end

    always_comb begin
        count_d       = count_q;
        valid_d       = tick;
        echo_d        = echo_q;
        beta_d        = beta_q;
        fill_cnt_d    = fill_cnt_q;
        state_d       = state_q;
        sound_d       = sound_q;
        sound_valid_d = valid_q;

        if (en) begin
            count_d = tick ? '0 : count_q + CW'(1);
        end
        if (tick) begin
            echo_d = echo;
            beta_d = gain_e'(beta);
        end
        if (valid_q) begin
            sound_d = (echo_wide > scaled) ? SIZE'(echo_wide - scaled) : '0;
            if (state_q == FILL) begin
                fill_cnt_d = fill_cnt_q + ADDR_SIZE'(1);
                if (fill_cnt_q == '1) begin
                    state_d = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q       <= '0;
            valid_q       <= 1'b0;
            echo_q        <= '0;
            beta_q        <= GAIN_ZERO;
            fill_cnt_q    <= '0;
            state_q       <= FILL;
            sound_q       <= '0;
            sound_valid_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            valid_q       <= valid_d;
            echo_q        <= echo_d;
            beta_q        <= beta_d;
            fill_cnt_q    <= fill_cnt_d;
            state_q       <= state_d;
            sound_q       <= sound_d;
            sound_valid_q <= sound_valid_d;
        end
    end

    assign sound       = sound_q;
    assign sound_valid = sound_valid_q;

endmodule
